// File: rtl/duc_mix_stream_pkg.sv
`default_nettype none
// ============================================================================
// Package : duc_pkg
// Purpose : Shared definitions for the duc_mix_stream up-converter slice:
//           config-bus addresses, CTRL bit positions, playback FSM encoding
//           and the scale/saturate helper used by the mixer output stage.
// Rev     : 1.0  initial release
// ============================================================================
package duc_pkg;

  // Config register map
  localparam logic [1:0] CFG_CTRL = 2'd0;
  localparam logic [1:0] CFG_LEN  = 2'd1;
  localparam logic [1:0] CFG_FW   = 2'd2;

  // CTRL register bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_MODE  = 3;

  // Playback FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } duc_state_e;

  // Arithmetic shift right by sh, then clamp into a signed w-bit range.
  // Works on a 64-bit container so one function serves every width; the
  // caller casts the result down to its lane width.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] val,
    input int unsigned        sh,
    input int unsigned        w
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = val >>> sh;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/duc_mix_stream_rate_en.sv
`default_nettype none
// ============================================================================
// Module  : duc_rate_en
// Purpose : Fractional rate clock-enable. A phase accumulator adds the
//           frequency word every cycle; the carry out of the add is the
//           enable strobe (rate = FW / 2**FW_W of clk). FW = 0 never fires.
// Ports   : clk   - clock
//           rst   - synchronous active-high reset (accumulator to 0)
//           fw_i  - frequency word
//           en_o  - enable strobe, combinational from accumulator and fw_i
// Rev     : 1.0  initial release
// ============================================================================
module duc_rate_en #(
  parameter int FW_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FW_W-1:0] fw_i,
  output logic            en_o
);

  logic [FW_W-1:0] acc_q;
  logic [FW_W:0]   w_sum;

  assign w_sum = {1'b0, acc_q} + {1'b0, fw_i};
  assign en_o  = w_sum[FW_W];

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= w_sum[FW_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/duc_mix_stream.sv
`default_nettype none
// ============================================================================
// Module  : duc_mix_stream
// Purpose : Single-clock digital up-converter. Plays a host-loaded complex
//           baseband buffer at a programmable rate (one-shot or looped),
//           mixes it with an external LO, scales/saturates and emits an
//           AXI-Stream with fixed-length packets.
// Ports   : clk, rst                     - clock, sync active-high reset
//           buf_we/buf_addr/buf_din      - baseband buffer write port
//           cfg_we/cfg_addr/cfg_din      - config bus (CTRL, LEN, FW)
//           lo_sin, lo_cos               - signed LO inputs
//           m_tvalid/m_tready/m_tdata/m_tlast - AXIS master {I_out,Q_out}
//           busy                         - playback active
//           done                         - 1-cycle end-of-playback pulse
//           ovf_cnt                      - saturating dropped-sample count
// Rev     : 1.0  initial release
// ============================================================================
module duc_mix_stream #(
  parameter int DW       = 16,
  parameter int AW       = 12,
  parameter int FW_W     = 32,
  parameter int PKT_LEN  = 256,
  parameter int IDLE_VAL = 3000,
  parameter int OCNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buf_we,
  input  logic [AW-1:0]        buf_addr,
  input  logic [2*DW-1:0]      buf_din,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [31:0]          cfg_din,
  input  logic signed [DW-1:0] lo_sin,
  input  logic signed [DW-1:0] lo_cos,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [2*DW-1:0]      m_tdata,
  output logic                 m_tlast,
  output logic                 busy,
  output logic                 done,
  output logic [OCNT_W-1:0]    ovf_cnt
);
  import duc_pkg::*;

  localparam int BC_W = $clog2(PKT_LEN);

  // ---------------- config registers ----------------
  logic            loop_q, mode_q;
  logic [AW-1:0]   len_q;
  logic [FW_W-1:0] fw_q;
  logic            w_ctrl_wr, w_start, w_stop, w_en;

  assign w_ctrl_wr = cfg_we && (cfg_addr == CFG_CTRL);
  assign w_stop    = w_ctrl_wr && cfg_din[CTRL_STOP];
  // stop wins over a simultaneous start
  assign w_start   = w_ctrl_wr && cfg_din[CTRL_START] && !cfg_din[CTRL_STOP];

  always_ff @(posedge clk) begin
    if (rst) begin
      loop_q <= 1'b0;
      mode_q <= 1'b0;
      len_q  <= '0;
      fw_q   <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_CTRL: begin
          loop_q <= cfg_din[CTRL_LOOP];
          mode_q <= cfg_din[CTRL_MODE];
        end
        CFG_LEN:  len_q <= cfg_din[AW-1:0];
        CFG_FW:   fw_q  <= cfg_din[FW_W-1:0];
        default:  ;
      endcase
    end
  end

  duc_rate_en #(.FW_W(FW_W)) u_rate_en (
    .clk  (clk),
    .rst  (rst),
    .fw_i (fw_q),
    .en_o (w_en)
  );

  // ---------------- playback FSM ----------------
  duc_state_e    state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          state_d = ST_PLAY;
          raddr_d = '0;
        end
      end
      ST_PLAY: begin
        if (w_stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (w_en) begin
          // LEN is inclusive: addresses 0..LEN are played
          if (raddr_q < len_q) begin
            raddr_d = raddr_q + 1'b1;
          end else if (loop_q) begin
            raddr_d = '0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      raddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_PLAY);
  assign done = done_q;

  // ---------------- baseband buffer RAM (not reset) ----------------
  logic [2*DW-1:0] ram_q [2**AW];
  logic [2*DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (buf_we) ram_q[buf_addr] <= buf_din;
    if (w_en)   rd_q <= ram_q[raddr_q];
  end

  // ---------------- mixer pipeline, advances on en ----------------
  // vld_q marks which stages hold real data so nothing is pushed until the
  // pipeline has filled after reset.
  logic [2:0]           vld_q;
  logic                 play1_q;
  logic signed [DW-1:0] bb_i_q, bb_q_q;
  logic signed [2*DW-1:0] p_ic_q, p_qs_q, p_is_q, p_qc_q;
  logic signed [2*DW:0] w_sum_i, w_sum_q;
  logic [DW-1:0]        w_i_out, w_q_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      play1_q <= 1'b0;
      bb_i_q  <= '0;
      bb_q_q  <= '0;
      p_ic_q  <= '0;
      p_qs_q  <= '0;
      p_is_q  <= '0;
      p_qc_q  <= '0;
    end else if (w_en) begin
      vld_q   <= {vld_q[1:0], 1'b1};
      // travels with the RAM read so the mux below picks the right source
      play1_q <= (state_q == ST_PLAY);
      if (play1_q) begin
        bb_i_q <= rd_q[2*DW-1:DW];
        bb_q_q <= rd_q[DW-1:0];
      end else begin
        bb_i_q <= DW'(IDLE_VAL);
        bb_q_q <= DW'(IDLE_VAL);
      end
      p_ic_q <= bb_i_q * lo_cos;
      p_qs_q <= bb_q_q * lo_sin;
      p_is_q <= bb_i_q * lo_sin;
      p_qc_q <= bb_q_q * lo_cos;
    end
  end

  always_comb begin
    if (mode_q) begin
      w_sum_i = (2*DW+1)'(p_ic_q) - (2*DW+1)'(p_qs_q);
      w_sum_q = (2*DW+1)'(p_is_q) + (2*DW+1)'(p_qc_q);
    end else begin
      w_sum_i = (2*DW+1)'(p_ic_q);
      w_sum_q = (2*DW+1)'(p_qs_q);
    end
  end

  assign w_i_out = DW'(sat_shift(64'(w_sum_i), DW - 1, DW));
  assign w_q_out = DW'(sat_shift(64'(w_sum_q), DW - 1, DW));

  // ---------------- 2-entry output buffer ----------------
  logic [2*DW-1:0]   ob_q [2];
  logic              ob_wr_q, ob_rd_q;
  logic [1:0]        ob_cnt_q;
  logic [BC_W-1:0]   beat_q;
  logic [OCNT_W-1:0] ovf_q;
  logic              w_push, w_pop, w_full, w_accept, w_drop;

  assign w_push   = w_en && vld_q[2];
  assign w_pop    = m_tvalid && m_tready;
  assign w_full   = (ob_cnt_q == 2'd2);
  // a pop in the same cycle frees the slot, so a full buffer still accepts
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ob_q[0]  <= '0;
      ob_q[1]  <= '0;
      ob_wr_q  <= 1'b0;
      ob_rd_q  <= 1'b0;
      ob_cnt_q <= '0;
      beat_q   <= '0;
      ovf_q    <= '0;
    end else begin
      if (w_accept) begin
        ob_q[ob_wr_q] <= {w_i_out, w_q_out};
        ob_wr_q       <= ~ob_wr_q;
      end
      if (w_pop) begin
        ob_rd_q <= ~ob_rd_q;
        beat_q  <= m_tlast ? '0 : beat_q + 1'b1;
      end
      ob_cnt_q <= ob_cnt_q + {1'b0, w_accept} - {1'b0, w_pop};
      if (w_drop && !(&ovf_q)) ovf_q <= ovf_q + 1'b1;
    end
  end

  assign m_tvalid = (ob_cnt_q != 2'd0);
  assign m_tdata  = ob_q[ob_rd_q];
  assign m_tlast  = m_tvalid && (beat_q == BC_W'(PKT_LEN - 1));
  assign ovf_cnt  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_duc_mix_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_duc_mix_stream
// Purpose : Directed self-checking bench for duc_mix_stream (default params).
//           Idle streaming, one-shot, loop/stop, mode-1 saturation,
//           backpressure/overflow and reset mid-packet.
// Rev     : 1.0  initial release
// ============================================================================
module tb_duc_mix_stream;

  localparam int DW = 16;
  localparam int AW = 12;

  // expected output words {I_out,Q_out}
  localparam logic [31:0] IDLE0  = 32'h0BB7_0000; // cos=7FFF sin=0
  localparam logic [31:0] IDLE_S = 32'h0BB7_05DC; // cos=7FFF sin=4000
  localparam logic [31:0] PLAY0  = 32'h03E7_FE0C; // {1000,-1000}
  localparam logic [31:0] PLAY1  = 32'hF830_03E8; // {-2000,2000}
  localparam logic [31:0] SAT1_P = 32'h0000_7FFF;
  localparam logic [31:0] SAT1_I = 32'h0000_E890;
  localparam logic [31:0] SAT2_P = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT2_I = 32'h176F_FFFF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 buf_we;
  logic [AW-1:0]        buf_addr;
  logic [2*DW-1:0]      buf_din;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [31:0]          cfg_din;
  logic signed [DW-1:0] lo_sin, lo_cos;
  logic                 m_tvalid, m_tready, m_tlast, busy, done;
  logic [2*DW-1:0]      m_tdata;
  logic [15:0]          ovf_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int beat_idx = 0;
  int tlast_seen = 0;
  logic [31:0] beats_q [$];
  int n, k, nplay, nother, first_i, last_i, start_b;

  always #5 clk = ~clk;

  duc_mix_stream dut (
    .clk      (clk),
    .rst      (rst),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_din  (cfg_din),
    .lo_sin   (lo_sin),
    .lo_cos   (lo_cos),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .busy     (busy),
    .done     (done),
    .ovf_cnt  (ovf_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records the handshake about to happen at the next edge, then advances.
  task automatic step();
    if (!rst && m_tvalid && m_tready) begin
      check("tlast_pos", m_tlast, ((beat_idx % 256) == 255));
      if (m_tlast) tlast_seen++;
      beats_q.push_back(m_tdata);
      beat_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
    step();
    cfg_we = 1'b0; cfg_din = '0;
  endtask

  task automatic buf_write(input logic [AW-1:0] a, input logic [31:0] d);
    buf_we = 1'b1; buf_addr = a; buf_din = d;
    step();
    buf_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; buf_we = 0; buf_addr = '0; buf_din = '0;
    cfg_we = 0; cfg_addr = '0; cfg_din = '0;
    lo_cos = 16'sh7FFF; lo_sin = 16'sh0000; m_tready = 1'b1;
    #1;
    repeat (3) step();

    // ---- reset state ----
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast",  m_tlast, 0);
    check("rst_tdata",  m_tdata, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_ovf",    ovf_cnt, 0);

    // ---- idle streaming, mode 0 ----
    rst = 1'b0;
    cfg_write(2'd2, 32'h8000_0000);
    n = 0;
    while (!m_tvalid && n < 50) begin step(); n++; end
    check("idle_first_wait", n < 50, 1);
    check("idle_first_data", m_tdata, IDLE0);
    start_b = beat_idx;
    repeat (100) step();
    check("idle_rate", beat_idx - start_b, 50);
    n = 0;
    while (beat_idx < 300 && n < 1000) begin step(); n++; end
    check("idle_300_wait", beat_idx >= 300, 1);
    check("idle_tlast_cnt", tlast_seen, 1);
    check("idle_data", beats_q[beats_q.size()-1], IDLE0);

    // ---- one-shot, LEN=3 ----
    lo_sin = 16'sh4000;
    for (int i = 0; i < 4; i++) buf_write(AW'(i), 32'h03E8_FC18);
    cfg_write(2'd1, 32'd3);
    repeat (10) step();
    beats_q.delete();
    n = 0;
    while (!m_tvalid && n < 20) begin step(); n++; end
    check("os_sync_wait", n < 20, 1);
    cfg_write(2'd0, 32'h1);
    check("os_busy_on", busy, 1);
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    check("os_busy_len", n, 7);
    check("os_done", done, 1);
    step();
    check("os_done_pulse", done, 0);
    repeat (30) step();
    nplay = 0; nother = 0; first_i = -1; last_i = -1;
    foreach (beats_q[i]) begin
      if (beats_q[i] == PLAY0) begin
        nplay++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end else if (beats_q[i] != IDLE_S) nother++;
    end
    check("os_play_beats", nplay, 4);
    check("os_contig", last_i - first_i, 3);
    check("os_other", nother, 0);
    check("os_resume", beats_q[beats_q.size()-1], IDLE_S);

    // ---- loop, LEN=1, then stop ----
    buf_write(1, 32'hF830_07D0);
    cfg_write(2'd1, 32'd1);
    beats_q.delete();
    cfg_write(2'd0, 32'h5);
    repeat (30) step();
    check("loop_busy", busy, 1);
    k = -1;
    foreach (beats_q[i]) if (k < 0 && beats_q[i] != IDLE_S) k = i;
    check("loop_found", (k >= 0) && (k + 5 < beats_q.size()), 1);
    if ((k >= 0) && (k + 5 < beats_q.size()))
      for (int j = 0; j < 6; j++)
        check("loop_seq", beats_q[k+j], (j % 2 == 0) ? PLAY0 : PLAY1);
    cfg_write(2'd0, 32'h2);
    check("stop_done", done, 1);
    check("stop_busy", busy, 0);
    step();
    check("stop_done_pulse", done, 0);

    // ---- start and stop together ----
    cfg_write(2'd0, 32'h3);
    check("ss_busy", busy, 0);
    check("ss_done", done, 0);
    step();
    check("ss_busy2", busy, 0);

    // ---- saturation, mode 1 ----
    buf_write(0, 32'h8000_8000);
    cfg_write(2'd1, 32'd0);
    lo_cos = 16'sh8000; lo_sin = 16'sh8000;
    cfg_write(2'd0, 32'h8);
    repeat (10) step();
    beats_q.delete();
    cfg_write(2'd0, 32'h9);
    repeat (30) step();
    nplay = 0;
    foreach (beats_q[i]) if (beats_q[i] == SAT1_P) nplay++;
    check("sat1_play", nplay, 1);
    check("sat1_idle", beats_q[beats_q.size()-1], SAT1_I);

    buf_write(0, 32'h7FFF_7FFF);
    lo_cos = 16'sh7FFF; lo_sin = 16'sh8000;
    repeat (10) step();
    beats_q.delete();
    cfg_write(2'd0, 32'h9);
    repeat (30) step();
    nplay = 0;
    foreach (beats_q[i]) if (beats_q[i] == SAT2_P) nplay++;
    check("sat2_play", nplay, 1);
    check("sat2_idle", beats_q[beats_q.size()-1], SAT2_I);

    // ---- backpressure ----
    cfg_write(2'd0, 32'h0);
    lo_cos = 16'sh7FFF; lo_sin = 16'sh0000;
    repeat (10) step();
    check("bp_ovf_pre", ovf_cnt, 0);
    n = 0;
    while (m_tvalid && n < 10) begin step(); n++; end
    check("bp_sync_wait", n < 10, 1);
    m_tready = 1'b0;
    repeat (4) step();
    check("bp_mid_valid", m_tvalid, 1);
    check("bp_mid_data", m_tdata, IDLE0);
    repeat (6) step();
    check("bp_valid", m_tvalid, 1);
    check("bp_data", m_tdata, IDLE0);
    check("bp_ovf", ovf_cnt, 3);
    m_tready = 1'b1;
    beats_q.delete();
    repeat (20) step();
    check("bp_drain", beats_q.size() >= 2, 1);
    check("bp_drain_data", beats_q[0], IDLE0);
    check("bp_ovf_hold", ovf_cnt, 3);

    // ---- reset mid-packet ----
    n = 0;
    while ((beat_idx % 256) != 100 && n < 3000) begin step(); n++; end
    check("rm_wait", (beat_idx % 256), 100);
    rst = 1'b1;
    step();
    check("rm_tvalid", m_tvalid, 0);
    check("rm_tlast", m_tlast, 0);
    check("rm_ovf", ovf_cnt, 0);
    check("rm_done", done, 0);
    rst = 1'b0;
    beat_idx = 0;
    tlast_seen = 0;
    cfg_write(2'd2, 32'h8000_0000);
    n = 0;
    while (beat_idx < 260 && n < 1000) begin step(); n++; end
    check("rm_260_wait", beat_idx >= 260, 1);
    check("rm_tlast_cnt", tlast_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
